// File: rtl/cdb_request_buffer.sv
`default_nettype none
// ============================================================================
// Module  : cdb_request_buffer
// Purpose : In-order result queue between one functional unit and the CDB arbiter.
// Revision: 1.0
// ============================================================================
module cdb_request_buffer #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     fuValid,
  input  logic [WIDTH:0]           fuResult,
  input  logic [ROB:0]             fuRob,
  input  logic                     grant,
  output logic                     request,
  output logic [WIDTH:0]           result,
  output logic [ROB:0]             robEntry,
  output logic                     available,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_EW = WIDTH + ROB + 2;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic [c_EW-1:0] r_mem [DEPTH];
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic [c_EW-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);
  assign w_pop   = grant && !w_empty;
  // A pop in the same edge frees the slot, so a push into a full queue is fine then.
  assign w_push  = fuValid && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CW'(1);
      end
      if (fuValid && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; contents are only observed through the valid head.
  always_ff @(posedge clk) begin
    if (!clear && w_push) begin
      r_mem[r_wr_ptr] <= {fuResult, fuRob};
    end
  end

  assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign result    = w_head[c_EW-1:ROB+1];
  assign robEntry  = w_head[ROB:0];
  assign request   = !w_empty;
  assign available = !w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cdb_request_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_request_buffer
// Purpose : Directed self-checking bench for cdb_request_buffer.
// Revision: 1.0
// ============================================================================
module tb_cdb_request_buffer;

  localparam int WIDTH = 31;
  localparam int ROB   = 2;
  localparam int DEPTH = 4;

  logic              clk;
  logic              clear;
  logic              fuValid;
  logic [WIDTH:0]    fuResult;
  logic [ROB:0]      fuRob;
  logic              grant;
  logic              request;
  logic [WIDTH:0]    result;
  logic [ROB:0]      robEntry;
  logic              available;
  logic [2:0]        count;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  cdb_request_buffer #(.WIDTH(WIDTH), .ROB(ROB), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .clear    (clear),
    .fuValid  (fuValid),
    .fuResult (fuResult),
    .fuRob    (fuRob),
    .grant    (grant),
    .request  (request),
    .result   (result),
    .robEntry (robEntry),
    .available(available),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH:0] v, input logic [ROB:0] r);
    fuValid  = 1'b1;
    fuResult = v;
    fuRob    = r;
    tick();
    fuValid  = 1'b0;
  endtask

  initial begin
    clear = 1'b1; fuValid = 1'b1; fuResult = 99; fuRob = 7; grant = 1'b1;
    tick();
    tick();
    chk("rst_request",   request,   0);
    chk("rst_count",     count,     0);
    chk("rst_available", available, 1);
    chk("rst_overflow",  overflow,  0);
    chk("rst_result",    result,    0);
    chk("rst_rob",       robEntry,  0);
    clear = 1'b0; fuValid = 1'b0; grant = 1'b0; fuResult = 0; fuRob = 0;
    tick();
    chk("idle_count", count, 0);

    // Single entry
    push(60, 1);
    chk("single_request", request,  1);
    chk("single_result",  result,   60);
    chk("single_rob",     robEntry, 1);
    chk("single_count",   count,    1);
    grant = 1'b1; tick(); grant = 1'b0;
    chk("single_pop_request", request, 0);
    chk("single_pop_result",  result,  0);
    chk("single_pop_count",   count,   0);

    // Fill and drain in order
    for (int i = 0; i < 4; i++) push(10 * (i + 1), 3'(i));
    chk("fill_count",     count,     4);
    chk("fill_available", available, 0);
    chk("fill_request",   request,   1);
    for (int i = 0; i < 4; i++) begin
      chk("order_result", result,   10 * (i + 1));
      chk("order_rob",    robEntry, i);
      grant = 1'b1; tick(); grant = 1'b0;
    end
    chk("drain_count",   count,   0);
    chk("drain_request", request, 0);

    // Simultaneous push/pop while full
    for (int i = 0; i < 4; i++) push(10 * (i + 1), 3'(i));
    fuValid = 1'b1; fuResult = 50; fuRob = 4; grant = 1'b1;
    tick();
    fuValid = 1'b0; grant = 1'b0;
    chk("fullpp_count",    count,    4);
    chk("fullpp_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_result", result, (i < 3) ? 10 * (i + 2) : 50);
      grant = 1'b1; tick(); grant = 1'b0;
    end
    chk("fullpp_count_end", count, 0);

    // Overflow is sticky until clear
    for (int i = 0; i < 4; i++) push(11 * (i + 1), 3'(i));
    push(55, 5);
    chk("ovf_count", count,    4);
    chk("ovf_flag",  overflow, 1);
    chk("ovf_head",  result,   11);
    for (int i = 0; i < 10; i++) tick();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_count_idle", count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_contents", result, 11 * (i + 1));
      chk("ovf_rob",      robEntry, i);
      grant = 1'b1; tick(); grant = 1'b0;
    end
    chk("ovf_after_drain", overflow, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("ovf_cleared", overflow, 0);
    chk("ovf_clr_count", count, 0);

    // Wrap-around: 9 push/pop pairs
    for (int i = 0; i < 9; i++) begin
      push(100 + i, 3'(i % 8));
      chk("wrap_result", result,   100 + i);
      chk("wrap_rob",    robEntry, i % 8);
      grant = 1'b1; tick(); grant = 1'b0;
      chk("wrap_count",  count,    0);
    end
    grant = 1'b1; tick(); grant = 1'b0;
    chk("spur_count",     count,     0);
    chk("spur_request",   request,   0);
    chk("spur_available", available, 1);
    chk("spur_overflow",  overflow,  0);
    push(70, 5);
    chk("post_wrap_result", result,   70);
    chk("post_wrap_rob",    robEntry, 5);
    chk("post_wrap_count",  count,    1);
    grant = 1'b1; tick(); grant = 1'b0;

    // Push into empty queue with grant: no bypass, entry stays queued
    fuValid = 1'b1; fuResult = 77; fuRob = 2; grant = 1'b1;
    tick();
    fuValid = 1'b0; grant = 1'b0;
    chk("nobypass_count",  count,  1);
    chk("nobypass_result", result, 77);

    // Steady throughput: grant and fuValid every cycle keeps count constant
    for (int i = 0; i < 3; i++) begin
      chk("thru_head", result, (i == 0) ? 77 : 200 + i - 1);
      fuValid = 1'b1; fuResult = 200 + i; fuRob = 3'(i); grant = 1'b1;
      tick();
      chk("thru_count", count, 1);
    end
    fuValid = 1'b0; grant = 1'b0;
    chk("thru_last", result, 202);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
